ir_nec_decoder: RTL

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_decoder_if.sv | 41 ++++
 rtl/ir_nec_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_decoder_if.sv
// ----------------------------------------------------------------------------
// ir_nec_decoder_if
//   Register-side bus of the NEC IR decoder.
//
//   Handshake: data_ready is a level that rises when a new valid frame is
//   placed in data and stays high until the wrapper pulses read for exactly
//   one cycle. data is stable while data_ready is high, except that a newer
//   valid frame overwrites it. A read while data_ready is low has no effect.
//   repeat_pulse and frame_err are one-cycle event strobes; they carry no
//   handshake and are never high together.
//
//   Signals
//     read          master -> slave  one-cycle read strobe
//     data_ready    slave  -> master new frame held in data, not yet read
//     data[31:0]    slave  -> master last valid frame, bit 0 = first bit
//     repeat_pulse  slave  -> master one-cycle pulse on a valid repeat code
//     frame_err     slave  -> master one-cycle pulse on an aborted/bad frame
// ----------------------------------------------------------------------------
interface ir_nec_decoder_if;
  logic        read;
  logic        data_ready;
  logic [31:0] data;
  logic        repeat_pulse;
  logic        frame_err;

  modport master (
    output read,
    input  data_ready,
    input  data,
    input  repeat_pulse,
    input  frame_err
  );

  modport slave (
    input  read,
    output data_ready,
    output data,
    output repeat_pulse,
    output frame_err
  );
endinterface

// File: rtl/ir_nec_decoder.sv
// ----------------------------------------------------------------------------
// ir_nec_decoder
//   Decodes NEC infrared frames from a demodulated receiver output.
//   The raw ir level is synchronised, glitch-filtered and edge-detected; a
//   20-bit saturating counter measures the length of each mark/space, and a
//   state machine classifies those lengths into leader, guard, data bits,
//   stop burst and repeat code.
//
//   Ports
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     ir         in   receiver output, asynchronous, idle high, mark = low
//     bus        slave modport of ir_nec_decoder_if (read / data_ready /
//                data / repeat_pulse / frame_err)
//     state_dbg  out  current FSM state (0 = IDLE, 1 = LEADER, 2 = GUARD,
//                3 = DATA_MARK, 4 = DATA_SPACE, 5 = REPEAT_MARK)
// ----------------------------------------------------------------------------
module ir_nec_decoder #(
  parameter int FILTER_CYC = 8,
  parameter int LEADER_MIN = 400000,
  parameter int GUARD_MIN  = 170000,
  parameter int REPEAT_MIN = 84000,
  parameter int BIT_THRESH = 56250,
  parameter int MARK_MAX   = 50000,
  parameter int SPACE_MAX  = 300000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ir,
  ir_nec_decoder_if.slave     bus,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W = 20;
  localparam int FW    = $clog2(FILTER_CYC + 1);

  localparam logic [CNT_W-1:0] LEADER_LIM  = CNT_W'(LEADER_MIN);
  localparam logic [CNT_W-1:0] LEADER_TO   = CNT_W'(2 * SPACE_MAX);
  localparam logic [CNT_W-1:0] GUARD_LIM   = CNT_W'(GUARD_MIN);
  localparam logic [CNT_W-1:0] REPEAT_LIM  = CNT_W'(REPEAT_MIN);
  localparam logic [CNT_W-1:0] BIT_LIM     = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MARK_TO     = CNT_W'(MARK_MAX);
  localparam logic [CNT_W-1:0] SPACE_TO    = CNT_W'(SPACE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [FW-1:0]    FILT_LAST   = FW'(FILTER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LEADER      = 3'd1,
    S_GUARD       = 3'd2,
    S_DATA_MARK   = 3'd3,
    S_DATA_SPACE  = 3'd4,
    S_REPEAT_MARK = 3'd5
  } state_t;

  state_t state, state_d;

  // Input conditioning
  logic             ir_s1, ir_s2;
  logic             filt, filt_q;
  logic [FW-1:0]    filt_cnt;
  logic             fall, rise, edge_any;

  // Timing and frame assembly
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      shift;
  logic             seen_valid;
  logic             bit_val;
  logic             cmd_ok;

  // FSM decisions
  logic             bit_clr;
  logic             bit_wr;
  logic             frame_ok;
  logic             err_d;
  logic             rep_d;

  // Output registers
  logic [31:0]      data_r;
  logic             ready_r;
  logic             rep_r;
  logic             err_r;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; idle level of the receiver is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_s1 <= 1'b1;
      ir_s2 <= 1'b1;
    end else begin
      ir_s1 <= ir;
      ir_s2 <= ir_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter: filt follows ir_s2 only after FILTER_CYC consecutive
  // samples that differ from the current filtered level. Any sample equal to
  // filt restarts the run, so short glitches never reach the FSM. Both edge
  // directions see the same delay, so measured lengths are preserved.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
    end else if (ir_s2 == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt     <= ir_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Edge detection against the previous filtered level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
    end else begin
      filt_q <= filt;
    end
  end

  assign fall     = filt_q & ~filt;
  assign rise     = ~filt_q & filt;
  assign edge_any = fall | rise;

  // --------------------------------------------------------------------------
  // Length counter: on an edge cycle cnt holds the length of the level that
  // just ended; it saturates so a long idle cannot wrap into a valid length.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (edge_any) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_val = (cnt >= BIT_LIM);
  // Extended NEC: only the command byte is checked against its inverse.
  assign cmd_ok  = (shift[31:24] == ~shift[23:16]);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and decisions. Edges take priority over timeouts; every
  // abort path drops back to IDLE, which then waits for a fresh falling edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state;
    bit_clr  = 1'b0;
    bit_wr   = 1'b0;
    frame_ok = 1'b0;
    err_d    = 1'b0;
    rep_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (fall) begin
          state_d = S_LEADER;
        end
      end

      S_LEADER: begin
        if (rise) begin
          // A short mark is treated as noise, not as a broken frame.
          state_d = (cnt >= LEADER_LIM) ? S_GUARD : S_IDLE;
        end else if (cnt >= LEADER_TO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_GUARD: begin
        if (fall) begin
          if (cnt >= GUARD_LIM) begin
            state_d = S_DATA_MARK;
            bit_clr = 1'b1;
          end else if (cnt >= REPEAT_LIM) begin
            state_d = S_REPEAT_MARK;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (cnt >= SPACE_TO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_DATA_MARK: begin
        if (rise) begin
          if (bit_cnt == 6'd32) begin
            // End of the stop burst: all 32 bits are in the shift register.
            state_d  = S_IDLE;
            frame_ok = cmd_ok;
            err_d    = ~cmd_ok;
          end else begin
            state_d = S_DATA_SPACE;
          end
        end else if (cnt >= MARK_TO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_DATA_SPACE: begin
        if (fall) begin
          state_d = S_DATA_MARK;
          bit_wr  = 1'b1;
        end else if (cnt >= SPACE_TO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_REPEAT_MARK: begin
        if (rise) begin
          state_d = S_IDLE;
          // A repeat code means nothing until a frame has been decoded.
          rep_d   = seen_valid;
        end else if (cnt >= MARK_TO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame assembly: bits arrive LSB first, so bit n lands at shift[n].
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_wr) begin
      shift[bit_cnt[4:0]] <= bit_val;
      bit_cnt             <= bit_cnt + 6'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers. A completing frame beats a coincident read so the
  // wrapper never loses the notification of the new frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= '0;
      ready_r    <= 1'b0;
      seen_valid <= 1'b0;
      rep_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (frame_ok) begin
        data_r     <= shift;
        ready_r    <= 1'b1;
        seen_valid <= 1'b1;
      end else if (bus.read) begin
        ready_r <= 1'b0;
      end
      rep_r <= rep_d;
      err_r <= err_d;
    end
  end

  assign bus.data         = data_r;
  assign bus.data_ready   = ready_r;
  assign bus.repeat_pulse = rep_r;
  assign bus.frame_err    = err_r;
  assign state_dbg        = state;

endmodule
